// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   One pipeline register between two adjacent stages (MEM->WB by default).
//   It carries the GPR write payload (address, enable, data) and the HI/LO
//   write payload (hi, lo, enable). It follows the central stall vector,
//   squashes its contents on flush, and marks inserted NOPs as bubbles.
//   Optional saturating bubble/hold counters are available for performance
//   debug when the macro PIPE_PERF_CNT_EN is defined. Without the macro the
//   counter ports still exist, are tied to zero, and no counter flops are
//   built. Payload behaviour is the same in both builds.
//
// Ports:
//   clk        in   1        clock, all state changes on the rising edge
//   rst        in   1        synchronous reset, active-high
//   stall      in   STALL_W  per-stage stall vector, 1 = stop
//   flush      in   1        squash the stage contents
//   in_wd      in   ADDR_W   upstream GPR write address
//   in_wreg    in   1        upstream GPR write enable
//   in_wdata   in   DATA_W   upstream GPR write data
//   in_hi      in   DATA_W   upstream HI value
//   in_lo      in   DATA_W   upstream LO value
//   in_whilo   in   1        upstream HI/LO write enable
//   out_wd     out  ADDR_W   registered GPR write address
//   out_wreg   out  1        registered GPR write enable
//   out_wdata  out  DATA_W   registered GPR write data
//   out_hi     out  DATA_W   registered HI value
//   out_lo     out  DATA_W   registered LO value
//   out_whilo  out  1        registered HI/LO write enable
//   out_bubble out  1        1 = register holds an inserted NOP
//   bubble_cnt out  CNT_W    saturating count of inserted bubbles
//   hold_cnt   out  CNT_W    saturating count of hold cycles
//
// Parameters:
//   STAGE selects the upstream stall bit; the downstream bit is STAGE+1,
//   so STAGE+1 must be below STALL_W. NOP_ADDR is the address shown while
//   the register holds a bubble. CNT_W only matters with PIPE_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 STALL_W  = 6,
  parameter int                 STAGE    = 4,
  parameter logic [ADDR_W-1:0]  NOP_ADDR = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  in_wd,
  input  logic               in_wreg,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [DATA_W-1:0]  in_hi,
  input  logic [DATA_W-1:0]  in_lo,
  input  logic               in_whilo,
  output logic [ADDR_W-1:0]  out_wd,
  output logic               out_wreg,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [DATA_W-1:0]  out_hi,
  output logic [DATA_W-1:0]  out_lo,
  output logic               out_whilo,
  output logic               out_bubble,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  // What the register does on the coming edge when reset is not asserted.
  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2,
    ACT_HOLD   = 2'd3
  } action_e;

  logic    upStall;
  logic    downStall;
  action_e action;

  // Only two bits of the stall vector matter here; the rest are folded into
  // a dummy so the whole vector counts as consumed.
  logic    unusedStallBits;

  logic [ADDR_W-1:0] wd_q,    wd_d;
  logic              wreg_q,  wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hi_q,    hi_d;
  logic [DATA_W-1:0] lo_q,    lo_d;
  logic              whilo_q, whilo_d;
  logic              bubble_q, bubble_d;

  assign upStall         = stall[STAGE];
  assign downStall       = stall[STAGE+1];
  assign unusedStallBits = ^stall;

  // Priority decode of the edge action. Flush beats any stall combination,
  // so a squash during a full stall still clears the stage. An upstream
  // stall with a free downstream stage pushes a bubble forward. The
  // downstream-only stall is not a legal ctrl output and simply loads.
  always_comb begin
    action = ACT_LOAD;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (upStall && !downStall) begin
      action = ACT_BUBBLE;
    end else if (!upStall) begin
      action = ACT_LOAD;
    end else begin
      action = ACT_HOLD;
    end
  end

  // Next-state payload. Flush and bubble both insert a NOP; a hold keeps
  // every field including the bubble flag, so a held bubble stays a bubble
  // and a held instruction stays valid.
  always_comb begin
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    whilo_d  = whilo_q;
    bubble_d = bubble_q;
    case (action)
      ACT_FLUSH, ACT_BUBBLE: begin
        wd_d     = NOP_ADDR;
        wreg_d   = 1'b0;
        wdata_d  = '0;
        hi_d     = '0;
        lo_d     = '0;
        whilo_d  = 1'b0;
        bubble_d = 1'b1;
      end
      ACT_LOAD: begin
        wd_d     = in_wd;
        wreg_d   = in_wreg;
        wdata_d  = in_wdata;
        hi_d     = in_hi;
        lo_d     = in_lo;
        whilo_d  = in_whilo;
        bubble_d = 1'b0;
      end
      default: begin
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        whilo_d  = whilo_q;
        bubble_d = bubble_q;
      end
    endcase
  end

  // Payload register. Reset loads the NOP values and marks a bubble; it
  // overrides any stall or flush on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q     <= NOP_ADDR;
      wreg_q   <= 1'b0;
      wdata_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      whilo_q  <= 1'b0;
      bubble_q <= 1'b1;
    end else begin
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      whilo_q  <= whilo_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_wd     = wd_q;
  assign out_wreg   = wreg_q;
  assign out_wdata  = wdata_q;
  assign out_hi     = hi_q;
  assign out_lo     = lo_q;
  assign out_whilo  = whilo_q;
  assign out_bubble = bubble_q;

`ifdef PIPE_PERF_CNT_EN

  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0] holdCnt_q,   holdCnt_d;

  // Counters stick at all-ones instead of wrapping so a long run still
  // reads as "at least this many". A flush inserts a NOP but is not a
  // stall-induced bubble, so it leaves both counters alone.
  always_comb begin
    bubbleCnt_d = bubbleCnt_q;
    holdCnt_d   = holdCnt_q;
    if (action == ACT_BUBBLE && bubbleCnt_q != '1) begin
      bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end
    if (action == ACT_HOLD && holdCnt_q != '1) begin
      holdCnt_d = holdCnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt_q <= '0;
      holdCnt_q   <= '0;
    end else begin
      bubbleCnt_q <= bubbleCnt_d;
      holdCnt_q   <= holdCnt_d;
    end
  end

  assign bubble_cnt = bubbleCnt_q;
  assign hold_cnt   = holdCnt_q;

`else

  assign bubble_cnt = '0;
  assign hold_cnt   = '0;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Two instances share all inputs: one
// with default parameters and one with CNT_W=2 and NOP_ADDR=31 so counter
// saturation and the NOP address parameter are both exercised. Counter
// expectations follow PIPE_PERF_CNT_EN: zero when the macro is undefined.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

`ifdef PIPE_PERF_CNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  localparam logic [4:0] SmallNop = 5'd31;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  inWd;
  logic        inWreg;
  logic [31:0] inWdata;
  logic [31:0] inHi;
  logic [31:0] inLo;
  logic        inWhilo;

  logic [4:0]  outWd,     sOutWd;
  logic        outWreg,   sOutWreg;
  logic [31:0] outWdata,  sOutWdata;
  logic [31:0] outHi,     sOutHi;
  logic [31:0] outLo,     sOutLo;
  logic        outWhilo,  sOutWhilo;
  logic        outBubble, sOutBubble;
  logic [15:0] bubbleCnt, holdCnt;
  logic [1:0]  sBubbleCnt, sHoldCnt;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Model of the expected raw counter values (before saturation/masking).
  int expBubbles = 0;
  int expHolds   = 0;

  pipe_stage_reg dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_wd      (inWd),
    .in_wreg    (inWreg),
    .in_wdata   (inWdata),
    .in_hi      (inHi),
    .in_lo      (inLo),
    .in_whilo   (inWhilo),
    .out_wd     (outWd),
    .out_wreg   (outWreg),
    .out_wdata  (outWdata),
    .out_hi     (outHi),
    .out_lo     (outLo),
    .out_whilo  (outWhilo),
    .out_bubble (outBubble),
    .bubble_cnt (bubbleCnt),
    .hold_cnt   (holdCnt)
  );

  pipe_stage_reg #(
    .CNT_W    (2),
    .NOP_ADDR (SmallNop)
  ) dutSmall (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_wd      (inWd),
    .in_wreg    (inWreg),
    .in_wdata   (inWdata),
    .in_hi      (inHi),
    .in_lo      (inLo),
    .in_whilo   (inWhilo),
    .out_wd     (sOutWd),
    .out_wreg   (sOutWreg),
    .out_wdata  (sOutWdata),
    .out_hi     (sOutHi),
    .out_lo     (sOutLo),
    .out_whilo  (sOutWhilo),
    .out_bubble (sOutBubble),
    .bubble_cnt (sBubbleCnt),
    .hold_cnt   (sHoldCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] st, input logic fl,
                               input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic [31:0] hi,
                               input logic [31:0] lo, input logic whilo);
    stall   = st;
    flush   = fl;
    inWd    = wd;
    inWreg  = wreg;
    inWdata = wdata;
    inHi    = hi;
    inLo    = lo;
    inWhilo = whilo;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Payload of both instances; the small one differs only in NOP address.
  task automatic checkPayload(input string tag, input logic [4:0] wd,
                              input logic wreg, input logic [31:0] wdata,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic whilo, input logic bubble);
    logic [4:0] sWd;
    sWd = bubble ? SmallNop : wd;
    checkOutput({tag, "/wd"},       64'(outWd),      64'(wd));
    checkOutput({tag, "/wreg"},     64'(outWreg),    64'(wreg));
    checkOutput({tag, "/wdata"},    64'(outWdata),   64'(wdata));
    checkOutput({tag, "/hi"},       64'(outHi),      64'(hi));
    checkOutput({tag, "/lo"},       64'(outLo),      64'(lo));
    checkOutput({tag, "/whilo"},    64'(outWhilo),   64'(whilo));
    checkOutput({tag, "/bubble"},   64'(outBubble),  64'(bubble));
    checkOutput({tag, "/s.wd"},     64'(sOutWd),     64'(sWd));
    checkOutput({tag, "/s.wdata"},  64'(sOutWdata),  64'(wdata));
    checkOutput({tag, "/s.bubble"}, 64'(sOutBubble), 64'(bubble));
  endtask

  task automatic checkNop(input string tag);
    checkPayload(tag, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic checkCounters(input string tag);
    int sb;
    int sh;
    sb = (expBubbles > 3) ? 3 : expBubbles;
    sh = (expHolds > 3) ? 3 : expHolds;
    checkOutput({tag, "/bubble_cnt"},   64'(bubbleCnt),  CntOn ? 64'(expBubbles) : 64'd0);
    checkOutput({tag, "/hold_cnt"},     64'(holdCnt),    CntOn ? 64'(expHolds)   : 64'd0);
    checkOutput({tag, "/s.bubble_cnt"}, 64'(sBubbleCnt), CntOn ? 64'(sb)         : 64'd0);
    checkOutput({tag, "/s.hold_cnt"},   64'(sHoldCnt),   CntOn ? 64'(sh)         : 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(6'b000000, 1'b0, 5'd9, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b1);

    // T1: reset for two edges with nonzero inputs.
    for (int i = 0; i < 2; i++) begin
      tick();
      checkNop("T1.reset");
      checkCounters("T1.reset");
    end

    // T2: plain load, latency one.
    rst = 1'b0;
    applyStimulus(6'b000000, 1'b0, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1);
    tick();
    checkPayload("T2.load", 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1, 1'b0);
    checkCounters("T2.load");

    // T3: upstream stall only, three bubbles.
    applyStimulus(6'b010000, 1'b0, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expBubbles++;
      checkNop("T3.bubble");
    end
    checkCounters("T3.bubble");

    // T4: load 0x1234, then hold for four cycles while inputs change.
    applyStimulus(6'b000000, 1'b0, 5'd7, 1'b1, 32'h1234, 32'h3, 32'h4, 1'b0);
    tick();
    checkPayload("T4.load", 5'd7, 1'b1, 32'h1234, 32'h3, 32'h4, 1'b0, 1'b0);
    applyStimulus(6'b110000, 1'b0, 5'd12, 1'b0, 32'h5555, 32'h66, 32'h77, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expHolds++;
      checkPayload("T4.hold", 5'd7, 1'b1, 32'h1234, 32'h3, 32'h4, 1'b0, 1'b0);
    end
    checkCounters("T4.hold");
    stall = 6'b000000;
    tick();
    checkPayload("T4.release", 5'd12, 1'b0, 32'h5555, 32'h66, 32'h77, 1'b1, 1'b0);

    // A bubble that is then held stays a bubble.
    stall = 6'b010000;
    tick();
    expBubbles++;
    checkNop("HB.bubble");
    stall = 6'b110000;
    tick();
    expHolds++;
    checkNop("HB.hold");
    checkCounters("HB.hold");

    // T5: flush during a full stall clears without counting a hold.
    stall = 6'b000000;
    tick();
    checkPayload("T5.load", 5'd12, 1'b0, 32'h5555, 32'h66, 32'h77, 1'b1, 1'b0);
    stall = 6'b110000;
    flush = 1'b1;
    tick();
    checkNop("T5.flush");
    checkCounters("T5.flush");
    flush = 1'b0;

    // Downstream-only stall and unrelated stall bits both load.
    applyStimulus(6'b100000, 1'b0, 5'd3, 1'b1, 32'hCAFE_F00D, 32'hAB, 32'hCD, 1'b1);
    tick();
    checkPayload("DS.load", 5'd3, 1'b1, 32'hCAFE_F00D, 32'hAB, 32'hCD, 1'b1, 1'b0);
    applyStimulus(6'b001111, 1'b0, 5'd30, 1'b0, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    tick();
    checkPayload("OB.load", 5'd30, 1'b0, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

    // Reset in the middle of a full stall wins and clears the counters.
    stall = 6'b110000;
    rst   = 1'b1;
    tick();
    expBubbles = 0;
    expHolds   = 0;
    checkNop("RS.reset");
    checkCounters("RS.reset");
    rst = 1'b0;
    tick();
    expHolds++;
    checkNop("RS.hold");

    // T6: five bubbles; the 2-bit counter saturates at 3.
    stall = 6'b010000;
    for (int i = 0; i < 5; i++) begin
      tick();
      expBubbles++;
    end
    checkNop("T6.bubble");
    checkCounters("T6.sat");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
